// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of PC/instruction
// pairs with valid/ready on both sides, wrong-path flush and head predecode.
module if_id_queue #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_instr,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_pc,
   output logic [31:0]              out_instr,
   output logic                     out_is_branch,
   output logic                     out_is_jal,
   output logic                     out_is_jalr,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [31:0]   NOP      = 32'h0000_0013;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [31:0]   pc_q    [DEPTH];
   logic [31:0]   instr_q [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic [31:0]   head_instr;

   // Handshake flags come only from registered occupancy, so no input reaches an output.
   assign in_ready  = (count != CNT_FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else if (flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            pc_q[wr_ptr]    <= in_pc;
            instr_q[wr_ptr] <= in_instr;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // An empty queue presents a NOP, which also zeroes every predecode field.
   assign head_instr    = out_valid ? instr_q[rd_ptr] : NOP;
   assign out_instr     = head_instr;
   assign out_pc        = out_valid ? pc_q[rd_ptr] : '0;
   assign out_is_branch = (head_instr[6:0] == OP_BRANCH);
   assign out_is_jal    = (head_instr[6:0] == OP_JAL);
   assign out_is_jalr   = (head_instr[6:0] == OP_JALR);
   assign out_rd        = head_instr[11:7];
   assign out_rs1       = head_instr[19:15];
   assign out_rs2       = head_instr[24:20];

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios on a DEPTH=2 instance and a randomized
// backpressure/wrap run on a DEPTH=4 instance checked against a queue model.
module tb_if_id_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        v2, fl2, ordy2, ir2, ov2, br2, jal2, jalr2;
   logic [31:0] pc2, ins2, opc2, oins2;
   logic [4:0]  rd2, rs1_2, rs2_2;
   logic [1:0]  cnt2;

   logic        v4, fl4, ordy4, ir4, ov4, br4, jal4, jalr4;
   logic [31:0] pc4, ins4, opc4, oins4;
   logic [4:0]  rd4, rs1_4, rs2_4;
   logic [2:0]  cnt4;

   int n_tests = 0;
   int n_fail  = 0;

   if_id_queue #(.DEPTH(2)) u2 (
      .clk(clk), .reset(reset), .in_valid(v2), .in_ready(ir2), .in_pc(pc2),
      .in_instr(ins2), .flush(fl2), .out_valid(ov2), .out_ready(ordy2),
      .out_pc(opc2), .out_instr(oins2), .out_is_branch(br2), .out_is_jal(jal2),
      .out_is_jalr(jalr2), .out_rd(rd2), .out_rs1(rs1_2), .out_rs2(rs2_2),
      .count(cnt2));

   if_id_queue #(.DEPTH(4)) u4 (
      .clk(clk), .reset(reset), .in_valid(v4), .in_ready(ir4), .in_pc(pc4),
      .in_instr(ins4), .flush(fl4), .out_valid(ov4), .out_ready(ordy4),
      .out_pc(opc4), .out_instr(oins4), .out_is_branch(br4), .out_is_jal(jal4),
      .out_is_jalr(jalr4), .out_rd(rd4), .out_rs1(rs1_4), .out_rs2(rs2_4),
      .count(cnt4));

   // All tasks enter and leave 1 time unit after a rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_tests++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL rst_init_ov got %b want 0", ov2); end
      n_tests++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL rst_init_ir got %b want 1", ir2); end
      n_tests++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL rst_init_cnt got %0d want 0", cnt2); end
      n_tests++; if (oins2 !== 32'h13) begin n_fail++; $display("FAIL rst_init_instr got %h want 00000013", oins2); end
      v2 = 1'b1; pc2 = 32'h100; ins2 = 32'h00C000EF;
      tick();
      v2 = 1'b0;
      n_tests++; if (cnt2 !== 2'd1) begin n_fail++; $display("FAIL rst_pre_cnt got %0d want 1", cnt2); end
      n_tests++; if (opc2 !== 32'h100) begin n_fail++; $display("FAIL rst_pre_pc got %h want 100", opc2); end
      // Assert reset mid-cycle, well away from any rising edge.
      #3 reset = 1'b1;
      #1;
      n_tests++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL rst_async_ov got %b want 0", ov2); end
      n_tests++; if (ir2 !== 1'b1) begin n_fail++; $display("FAIL rst_async_ir got %b want 1", ir2); end
      n_tests++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL rst_async_cnt got %0d want 0", cnt2); end
      n_tests++; if (oins2 !== 32'h13) begin n_fail++; $display("FAIL rst_async_instr got %h want 00000013", oins2); end
      n_tests++; if (opc2 !== 32'h0 || jal2 !== 1'b0 || rd2 !== 5'd0) begin
         n_fail++; $display("FAIL rst_async_head got pc=%h jal=%b rd=%0d want 0/0/0", opc2, jal2, rd2); end
      reset = 1'b0;
      tick();
      n_tests++; if (cnt2 !== 2'd0 || ov2 !== 1'b0) begin
         n_fail++; $display("FAIL rst_residue got cnt=%0d ov=%b want 0/0", cnt2, ov2); end
   endtask

   task automatic test_stream();
      ordy2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v2 = 1'b1; pc2 = 32'(i * 4); ins2 = 32'h13;
         tick();
         n_tests++; if (opc2 !== 32'(i * 4)) begin n_fail++; $display("FAIL stream_pc%0d got %h want %h", i, opc2, i * 4); end
         n_tests++; if (cnt2 !== 2'd1) begin n_fail++; $display("FAIL stream_cnt%0d got %0d want 1", i, cnt2); end
      end
      v2 = 1'b0;
      tick();
      ordy2 = 1'b0;
      n_tests++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL stream_drain got %0d want 0", cnt2); end
   endtask

   task automatic test_fill_stall();
      ordy2 = 1'b0;
      v2 = 1'b1; pc2 = 32'h10; tick();
      pc2 = 32'h14; tick();
      n_tests++; if (cnt2 !== 2'd2 || ir2 !== 1'b0) begin
         n_fail++; $display("FAIL fill_full got cnt=%0d ir=%b want 2/0", cnt2, ir2); end
      pc2 = 32'h18; tick();
      n_tests++; if (cnt2 !== 2'd2 || opc2 !== 32'h10) begin
         n_fail++; $display("FAIL fill_reject got cnt=%0d pc=%h want 2/10", cnt2, opc2); end
      ordy2 = 1'b1; tick();
      ordy2 = 1'b0;
      n_tests++; if (opc2 !== 32'h14 || cnt2 !== 2'd1 || ir2 !== 1'b1) begin
         n_fail++; $display("FAIL fill_release got pc=%h cnt=%0d ir=%b want 14/1/1", opc2, cnt2, ir2); end
      tick();
      v2 = 1'b0;
      n_tests++; if (cnt2 !== 2'd2) begin n_fail++; $display("FAIL fill_accept18 got cnt=%0d want 2", cnt2); end
      ordy2 = 1'b1; tick();
      n_tests++; if (opc2 !== 32'h18) begin n_fail++; $display("FAIL fill_order got %h want 18", opc2); end
      tick();
      ordy2 = 1'b0;
      n_tests++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL fill_drain got %0d want 0", cnt2); end
   endtask

   task automatic test_flush();
      ordy2 = 1'b0;
      v2 = 1'b1; pc2 = 32'h30; tick();
      pc2 = 32'h34; tick();
      fl2 = 1'b1; pc2 = 32'h40; tick();
      fl2 = 1'b0; v2 = 1'b0;
      n_tests++; if (cnt2 !== 2'd0 || ov2 !== 1'b0 || ir2 !== 1'b1) begin
         n_fail++; $display("FAIL flush_clear got cnt=%0d ov=%b ir=%b want 0/0/1", cnt2, ov2, ir2); end
      v2 = 1'b1; pc2 = 32'h80; tick();
      v2 = 1'b0;
      n_tests++; if (ov2 !== 1'b1 || opc2 !== 32'h80 || cnt2 !== 2'd1) begin
         n_fail++; $display("FAIL flush_target got ov=%b pc=%h cnt=%0d want 1/80/1", ov2, opc2, cnt2); end
      ordy2 = 1'b1; tick();
      ordy2 = 1'b0;
      n_tests++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL flush_drain got %0d want 0", cnt2); end
   endtask

   task automatic test_predecode();
      logic [31:0] instrs [3];
      logic [2:0]  flags  [3];
      logic [4:0]  rds    [3];
      logic [4:0]  rs1s   [3];
      logic [4:0]  rs2s   [3];
      instrs[0] = 32'h00C000EF; flags[0] = 3'b010; rds[0] = 5'd1;  rs1s[0] = 5'd0; rs2s[0] = 5'd12;
      instrs[1] = 32'hFE208EE3; flags[1] = 3'b100; rds[1] = 5'd29; rs1s[1] = 5'd1; rs2s[1] = 5'd2;
      instrs[2] = 32'h00008067; flags[2] = 3'b001; rds[2] = 5'd0;  rs1s[2] = 5'd1; rs2s[2] = 5'd0;
      for (int i = 0; i < 3; i++) begin
         v2 = 1'b1; pc2 = 32'h200 + 32'(i * 4); ins2 = instrs[i];
         tick();
         v2 = 1'b0;
         n_tests++; if ({br2, jal2, jalr2} !== flags[i]) begin
            n_fail++; $display("FAIL pre_flags%0d got %b want %b", i, {br2, jal2, jalr2}, flags[i]); end
         n_tests++; if (rd2 !== rds[i] || rs1_2 !== rs1s[i] || rs2_2 !== rs2s[i]) begin
            n_fail++; $display("FAIL pre_regs%0d got rd=%0d rs1=%0d rs2=%0d want %0d/%0d/%0d",
                               i, rd2, rs1_2, rs2_2, rds[i], rs1s[i], rs2s[i]); end
         ordy2 = 1'b1; tick();
         ordy2 = 1'b0;
      end
   endtask

   task automatic test_wrap_random();
      logic [63:0] q[$];
      int pushed = 0;
      int cyc = 0;
      bit acc, dq;
      while ((pushed < 20 || q.size() != 0) && cyc < 1000) begin
         n_tests++; if (cnt4 !== 3'(q.size()) || ov4 !== (q.size() != 0) || ir4 !== (q.size() != 4)) begin
            n_fail++; $display("FAIL wrap_flags cyc%0d got cnt=%0d ov=%b ir=%b want cnt=%0d", cyc, cnt4, ov4, ir4, q.size()); end
         if (q.size() != 0) begin
            n_tests++; if ({opc4, oins4} !== q[0]) begin
               n_fail++; $display("FAIL wrap_head cyc%0d got %h want %h", cyc, {opc4, oins4}, q[0]); end
         end
         v4    = (pushed < 20) && ($urandom_range(0, 3) != 0);
         ordy4 = ($urandom_range(0, 2) != 0);
         pc4   = 32'h1000 + 32'(pushed * 4);
         ins4  = $urandom;
         acc = v4 && (q.size() != 4);
         dq  = ordy4 && (q.size() != 0);
         if (dq) void'(q.pop_front());
         if (acc) begin q.push_back({pc4, ins4}); pushed++; end
         tick();
         cyc++;
      end
      v4 = 1'b0; ordy4 = 1'b0;
      n_tests++; if (cyc >= 1000) begin n_fail++; $display("FAIL wrap_timeout got %0d pushed want 20 drained", pushed); end
   endtask

   initial begin
      reset = 1'b1;
      v2 = 0; fl2 = 0; ordy2 = 0; pc2 = 0; ins2 = 0;
      v4 = 0; fl4 = 0; ordy4 = 0; pc4 = 0; ins4 = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      test_reset();
      test_stream();
      test_fill_stall();
      test_flush();
      test_predecode();
      test_wrap_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
